waveform_capture: RTL and testbench

WAVEFORM_CAPTURE -- requirements
Module: waveform_capture

---
 rtl/waveform_capture.sv | 137 +++++++++++++
 tb/tb_waveform_capture.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/waveform_capture.sv
// Triggered waveform capture: waits for a rising threshold crossing or a
// software force, records DEPTH consecutive valid ADC samples, then freezes
// the record for HOLD_CYCLES clocks while a downstream sender reads it.
module waveform_capture #(
   parameter int DEPTH       = 500,
   parameter int HOLD_CYCLES = 16000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] adc_data,
   input  logic        adc_valid,
   input  logic [13:0] threshold,
   input  logic        force_trig,
   output logic [13:0] waveform [DEPTH],
   output logic        acquire,
   output logic [1:0]  state,
   output logic [9:0]  sample_index,
   output logic [15:0] trig_count
);

   localparam int              HOLD_W     = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [9:0]      LAST_INDEX = 10'(DEPTH - 1);

   typedef enum logic [1:0] {
      ARMED   = 2'b00,
      CAPTURE = 2'b01,
      HOLD    = 2'b10
   } state_t;

   state_t            state_reg;
   logic              acquire_reg;
   logic              pending_reg;
   logic [9:0]        index_reg;
   logic [15:0]       trig_count_reg;
   logic [HOLD_W-1:0] hold_cnt_reg;
   logic [13:0]       prev_sample_reg;
   logic              prev_ok_reg;

   logic crossing;
   logic trigger;
   logic capture_write;
   logic last_write;

   // A sample equal to threshold crosses; a previous sample equal to it does not.
   assign crossing      = prev_ok_reg && (prev_sample_reg < threshold) && (adc_data >= threshold);
   assign trigger       = (state_reg == ARMED) && adc_valid && (crossing || pending_reg || force_trig);
   assign capture_write = (state_reg == CAPTURE) && adc_valid;
   assign last_write    = capture_write && (index_reg == LAST_INDEX);

   // Previous-sample tracker, runs on every valid sample regardless of state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prev_sample_reg <= '0;
         prev_ok_reg     <= 1'b0;
      end else if (adc_valid) begin
         prev_sample_reg <= adc_data;
         prev_ok_reg     <= 1'b1;
      end
   end

   // Capture sequencer: arm, fill the record, then hold it stable for the sender.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ARMED;
         acquire_reg    <= 1'b1;
         pending_reg    <= 1'b0;
         index_reg      <= '0;
         trig_count_reg <= '0;
         hold_cnt_reg   <= '0;
      end else begin
         case (state_reg)
            ARMED: begin
               if (trigger) begin
                  state_reg   <= CAPTURE;
                  index_reg   <= 10'd1;
                  pending_reg <= 1'b0;
               end else if (force_trig) begin
                  pending_reg <= 1'b1;
               end
            end
            CAPTURE: begin
               if (capture_write) begin
                  index_reg <= index_reg + 10'd1;
                  if (last_write) begin
                     state_reg      <= HOLD;
                     acquire_reg    <= 1'b0;
                     hold_cnt_reg   <= '0;
                     trig_count_reg <= trig_count_reg + 16'd1;
                  end
               end
            end
            HOLD: begin
               hold_cnt_reg <= hold_cnt_reg + 1'b1;
               if (hold_cnt_reg == HOLD_LAST) begin
                  state_reg   <= ARMED;
                  acquire_reg <= 1'b1;
                  index_reg   <= '0;
               end
            end
            default: begin
               // Encoding 11 is never entered deliberately; fall back to a clean arm.
               state_reg   <= ARMED;
               acquire_reg <= 1'b1;
               pending_reg <= 1'b0;
               index_reg   <= '0;
            end
         endcase
      end
   end

   // One register per record entry; the trigger sample lands in entry 0.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [13:0] entry_reg;
         logic        entry_we;

         assign entry_we = (trigger && (gi == 0)) || (capture_write && (index_reg == 10'(gi)));

         // Entry write, retained until rewritten by a later capture.
         always_ff @(posedge clk or posedge reset) begin
            if (reset)
               entry_reg <= '0;
            else if (entry_we)
               entry_reg <= adc_data;
         end

         assign waveform[gi] = entry_reg;
      end
   endgenerate

   assign acquire      = acquire_reg;
   assign state        = state_reg;
   assign sample_index = index_reg;
   assign trig_count   = trig_count_reg;

endmodule

// File: tb/tb_waveform_capture.sv
// Directed bench for waveform_capture with a small record and short hold.
module tb_waveform_capture;

   localparam int DEPTH = 8;
   localparam int HOLD  = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] adc_data;
   logic        adc_valid;
   logic [13:0] threshold;
   logic        force_trig;
   logic [13:0] waveform [DEPTH];
   logic        acquire;
   logic [1:0]  state;
   logic [9:0]  sample_index;
   logic [15:0] trig_count;

   int tests_run = 0;
   int tests_failed = 0;

   waveform_capture #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk),
      .reset(reset),
      .adc_data(adc_data),
      .adc_valid(adc_valid),
      .threshold(threshold),
      .force_trig(force_trig),
      .waveform(waveform),
      .acquire(acquire),
      .state(state),
      .sample_index(sample_index),
      .trig_count(trig_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // Advance one clock; outputs are looked at 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int value);
      adc_valid = 1'b1;
      adc_data  = 14'(value);
      tick();
   endtask

   // Run through HOLD feeding a constant valid sample; returns clocks spent with acquire low.
   task automatic wait_hold(input int value, output int n);
      n = 0;
      adc_valid = 1'b1;
      adc_data  = 14'(value);
      while (acquire == 1'b0 && n < 4 * HOLD) begin
         tick();
         n++;
      end
   endtask

   int n;

   initial begin
      reset      = 1'b1;
      adc_data   = '0;
      adc_valid  = 1'b0;
      threshold  = 14'd1000;
      force_trig = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_state", state, 0);
      check("rst_acquire", acquire, 1);
      check("rst_index", sample_index, 0);
      check("rst_trig_count", trig_count, 0);
      for (int i = 0; i < DEPTH; i++) check($sformatf("rst_wf%0d", i), waveform[i], 0);
      reset = 1'b0;
      tick();

      // First valid sample after reset only loads prev_sample
      sample(2000);
      check("first_valid_no_trig", state, 0);
      // 900 -> 1100 crossing
      sample(900);
      check("below_no_trig", state, 0);
      sample(1100);
      check("cross_state", state, 1);
      check("cross_wf0", waveform[0], 1100);
      check("cross_index", sample_index, 1);
      for (int k = 1; k < DEPTH; k++) begin
         sample(k);
         if (k == DEPTH - 2) check("acq_before_last", acquire, 1);
      end
      check("last_acquire", acquire, 0);
      check("last_state", state, 2);
      check("last_trig_count", trig_count, 1);
      for (int k = 1; k < DEPTH; k++) check($sformatf("ramp_wf%0d", k), waveform[k], k);

      // Hold: crossings and force ignored, record frozen, exact length
      force_trig = 1'b1;
      wait_hold(2000, n);
      force_trig = 1'b0;
      check("hold_len", n, HOLD);
      check("hold_exit_state", state, 0);
      check("hold_exit_index", sample_index, 0);
      check("hold_wf0", waveform[0], 1100);
      check("hold_wf7", waveform[DEPTH-1], DEPTH - 1);
      sample(500);
      check("no_pending_from_hold", state, 0);

      // Force with no valid, sample 5 two cycles later
      adc_valid  = 1'b0;
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      check("force_pending_wait", state, 0);
      tick();
      sample(5);
      check("force_state", state, 1);
      check("force_wf0", waveform[0], 5);
      for (int k = 1; k < DEPTH; k++) sample((k % 2 == 1) ? 900 : 1100);
      check("force_wf0_kept", waveform[0], 5);
      check("force_wf1", waveform[1], 900);
      check("force_wf2", waveform[2], 1100);
      check("force_end_state", state, 2);
      check("force_trig_count", trig_count, 2);
      wait_hold(1000, n);
      check("hold2_len", n, HOLD);

      // Prev equal to threshold does not cross; sample equal to it does
      sample(1000);
      check("eq_prev_1000", state, 0);
      sample(1001);
      check("eq_prev_1001", state, 0);
      sample(999);
      check("below_999", state, 0);
      sample(1000);
      check("eq_sample_trig", state, 1);
      check("eq_sample_wf0", waveform[0], 1000);
      for (int k = 0; k < 3; k++) sample(0);
      check("mid_index", sample_index, 4);

      // Asynchronous reset mid-capture
      adc_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("async_state", state, 0);
      check("async_acquire", acquire, 1);
      check("async_index", sample_index, 0);
      check("async_trig_count", trig_count, 0);
      check("async_wf0", waveform[0], 0);
      check("async_wf1", waveform[1], 0);
      #1;
      reset = 1'b0;
      sample(0);
      check("post_rst_first", state, 0);
      sample(2000);
      check("post_rst_second", state, 1);
      check("post_rst_wf0", waveform[0], 2000);

      // Gapped valid, one in four
      for (int k = 1; k < DEPTH; k++) begin
         for (int c = 0; c < 4; c++) begin
            adc_valid = (c == 3);
            adc_data  = 14'(100 + k);
            tick();
            check($sformatf("gap_idx_k%0d_c%0d", k, c), sample_index, (c == 3) ? k + 1 : k);
         end
      end
      check("gap_state", state, 2);
      check("gap_trig_count", trig_count, 1);
      check("gap_wf0", waveform[0], 2000);
      for (int k = 1; k < DEPTH; k++) check($sformatf("gap_wf%0d", k), waveform[k], 100 + k);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
